// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide engine. Shift-add multiply and restoring divide,
// one bit per cycle. Optional MULDIV_EARLY_EXIT_EN retires a multiply once the remaining multiplier bits are zero.
module muldiv_unit #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // state  | meaning
   // S_IDLE | waiting for start; operands sampled on acceptance
   // S_MUL  | shift-add, one multiplier bit per cycle
   // S_DIV  | restoring divide, one quotient bit per cycle
   // S_FIX  | sign correction, hi/lo registered
   // S_DONE | done pulse (div_zero too if divisor was zero)
   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t               state, state_nxt;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     mcand;
   logic [CNT_W-1:0]     cnt;
   logic                 div_r, neg_q, neg_r, dz_r;
   logic                 sign_a, sign_b;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [WIDTH:0]       mul_sum, div_up;
   logic [WIDTH-1:0]     div_diff;
   logic [2*WIDTH-1:0]   mul_step, mul_next, div_step, prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;
   logic                 mul_last;
`ifdef MULDIV_EARLY_EXIT_EN
   logic [CNT_W-1:0]     cnt_m1;
   logic [WIDTH-1:0]     rest_mask;
`endif

   assign sign_a = ~op[0] & a[WIDTH-1];
   assign sign_b = ~op[0] & b[WIDTH-1];
   assign abs_a  = sign_a ? -a : a;
   assign abs_b  = sign_b ? -b : b;

   // acc holds {partial product, unshifted multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      mul_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
      div_up   = acc[2*WIDTH-1:WIDTH-1];
      div_diff = div_up[WIDTH-1:0] - mcand;
      div_step = (div_up >= {1'b0, mcand}) ? {div_diff, acc[WIDTH-2:0], 1'b1}
                                           : {div_up[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      prod_fix = neg_q ? -acc : acc;
      quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_EARLY_EXIT_EN
      // remaining multiplier bits sit in the low cnt-1 positions after this step
      cnt_m1    = cnt - CNT_W'(1);
      rest_mask = ~({WIDTH{1'b1}} << cnt_m1);
      mul_last  = (mul_step[WIDTH-1:0] & rest_mask) == '0;
      mul_next  = mul_step >> cnt_m1;
`else
      mul_last  = (cnt == CNT_W'(1));
      mul_next  = mul_step;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      div_zero  = (state == S_DONE) & dz_r;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (!op[1])         state_nxt = S_MUL;
               else if (b == '0)   state_nxt = S_DONE;
               else                state_nxt = S_DIV;
            end
         end
         S_MUL:   if (mul_last) state_nxt = S_FIX;
         S_DIV:   if (cnt == CNT_W'(1)) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc   <= '0;
         mcand <= '0;
         cnt   <= '0;
         div_r <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz_r  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  div_r <= op[1];
                  neg_q <= sign_a ^ sign_b;
                  neg_r <= op[1] & sign_a;
                  dz_r  <= op[1] & (b == '0);
                  cnt   <= CNT_W'(WIDTH);
                  if (op[1]) begin
                     acc   <= {{WIDTH{1'b0}}, abs_a};
                     mcand <= abs_b;
                  end else begin
                     acc   <= {{WIDTH{1'b0}}, abs_b};
                     mcand <= abs_a;
                  end
               end
            end
            S_MUL: begin
               acc <= mul_next;
               cnt <= cnt - CNT_W'(1);
            end
            S_DIV: begin
               acc <= div_step;
               cnt <= cnt - CNT_W'(1);
            end
            S_FIX: begin
               if (div_r) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed table, handshake/abort
// sequences and random ops against an arithmetic reference model.
module tb_muldiv_unit;
   localparam int W = 32;

   logic          clock, reset, start;
   logic [1:0]    op;
   logic [W-1:0]  a, b;
   logic          busy, done, div_zero;
   logic [W-1:0]  hi, lo;

   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] cur_hi, cur_lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, hi, lo;
      logic         dz;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_lat(input string name, input logic [1:0] o, input logic dz, input int lat);
`ifdef MULDIV_EARLY_EXIT_EN
      if (!o[1]) begin
         chk(name, 64'(lat >= 3 && lat <= W + 2), 64'd1);
         return;
      end
`endif
      chk(name, 64'(lat), dz ? 64'd1 : 64'(W + 2));
   endtask

   // Reference: plain arithmetic. Returns {div_zero, hi, lo}.
   function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] xa, xb, ph, pl);
      longint      sa, sb;
      logic [63:0] ua, ub, p;
      sa = longint'($signed(xa));
      sb = longint'($signed(xb));
      ua = {32'b0, xa};
      ub = {32'b0, xb};
      case (o)
         2'd0: begin p = 64'(sa * sb); return {1'b0, p}; end
         2'd1: begin p = ua * ub;      return {1'b0, p}; end
         2'd2: begin
            if (xb == 0) return {1'b1, ph, pl};
            return {1'b0, 32'(sa % sb), 32'(sa / sb)};
         end
         default: begin
            if (xb == 0) return {1'b1, ph, pl};
            return {1'b0, 32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   // Launch one op from IDLE; lat counts edges with the accepting edge as 1.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] xa, xb,
                         output int lat, output logic [W-1:0] rhi, rlo,
                         output logic rdz, output logic stable);
      logic [W-1:0] h0, l0;
      h0 = hi; l0 = lo;
      stable = 1'b1;
      lat = -1; rhi = '0; rlo = '0; rdz = 1'b0;
      start = 1'b1; op = o; a = xa; b = xb;
      for (int k = 1; k <= W + 10; k++) begin
         @(posedge clock); #1;
         if (k == 1) begin
            start = 1'b0;
            a = $urandom;
            b = $urandom;
         end
         if (!busy) stable = 1'b0;
         if (done) begin
            lat = k; rhi = hi; rlo = lo; rdz = div_zero;
            break;
         end
         if (hi !== h0 || lo !== l0 || div_zero !== 1'b0) stable = 1'b0;
      end
      @(posedge clock); #1;
   endtask

   initial begin
      int           lat;
      logic [W-1:0] rhi, rlo;
      logic         rdz, stable, saw;
      logic [2*W:0] exp;
      logic [1:0]   o;
      logic [W-1:0] xa, xb;

      vecs[0]  = '{2'd0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[1]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{2'd3, 32'hFFFFFFF9, 32'h2,        32'h00000001, 32'h7FFFFFFC, 1'b0};
      vecs[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[5]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[6]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      vecs[7]  = '{2'd2, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[8]  = '{2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
      vecs[9]  = '{2'd3, 32'h451,      32'h20,       32'h00000011, 32'h00000022, 1'b0};
      vecs[10] = '{2'd2, 32'h5,        32'h0,        32'h00000011, 32'h00000022, 1'b1};
      vecs[11] = '{2'd1, 32'h0,        32'h12345,    32'h00000000, 32'h00000000, 1'b0};

      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_div_zero", div_zero, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      reset = 1'b0;
      @(posedge clock); #1;

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, rhi, rlo, rdz, stable);
         chk($sformatf("vec%0d_hi", i), rhi, vecs[i].hi);
         chk($sformatf("vec%0d_lo", i), rlo, vecs[i].lo);
         chk($sformatf("vec%0d_dz", i), rdz, vecs[i].dz);
         chk_lat($sformatf("vec%0d_lat", i), vecs[i].op, vecs[i].dz, lat);
         chk($sformatf("vec%0d_stable", i), stable, 1);
      end

`ifdef MULDIV_EARLY_EXIT_EN
      run_op(2'd1, 32'h55, 32'h1, lat, rhi, rlo, rdz, stable);
      chk("early_lat", 64'(lat), 64'd3);
      chk("early_lo", rlo, 32'h55);
`endif

      // start held high through busy and the DONE cycle: second op waits for IDLE
      start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7;
      @(posedge clock); #1;
      op = 2'd3; a = 32'd9; b = 32'd9;
      lat = -1;
      for (int k = 1; k <= W + 10; k++) begin
         if (done) begin lat = k; break; end
         @(posedge clock); #1;
      end
      chk_lat("hold_lat", 2'd1, 1'b0, lat);
      chk("hold_hi", hi, 0);
      chk("hold_lo", lo, 42);
      @(posedge clock); #1;
      chk("done_start_ignored", busy, 0);
      @(posedge clock); #1;
      chk("next_start_accepted", busy, 1);
      start = 1'b0;
      saw = 1'b0;
      for (int k = 0; k <= W + 10; k++) begin
         if (done) begin saw = 1'b1; break; end
         @(posedge clock); #1;
      end
      chk("b2b_done_seen", saw, 1);
      chk("b2b_hi", hi, 0);
      chk("b2b_lo", lo, 1);
      @(posedge clock); #1;

      // abort: restart attempt while busy, then reset mid-operation
      start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd5; saw = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clock); #1;
         if (k == 1) start = 1'b0;
         if (k == 5) begin start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd3; end
         if (done) saw = 1'b1;
      end
      reset = 1'b1; start = 1'b0;
      @(posedge clock); #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      chk("abort_no_done", saw, 0);
      reset = 1'b0;
      for (int k = 0; k < W + 5; k++) begin
         @(posedge clock); #1;
         if (done || busy) saw = 1'b1;
      end
      chk("abort_stays_idle", saw, 0);
      cur_hi = '0; cur_lo = '0;

      for (int i = 0; i < 40; i++) begin
         o  = 2'($urandom_range(0, 3));
         xa = $urandom;
         case ($urandom_range(0, 7))
            0:       xb = '0;
            1:       xb = 32'($urandom_range(1, 15));
            2:       xb = -32'($urandom_range(1, 15));
            default: xb = $urandom;
         endcase
         if (i % 9 == 0) xa = 32'h80000000;
         exp = model(o, xa, xb, cur_hi, cur_lo);
         run_op(o, xa, xb, lat, rhi, rlo, rdz, stable);
         chk($sformatf("rnd%0d_hi op%0d a=%h b=%h", i, o, xa, xb), rhi, exp[2*W-1:W]);
         chk($sformatf("rnd%0d_lo op%0d a=%h b=%h", i, o, xa, xb), rlo, exp[W-1:0]);
         chk($sformatf("rnd%0d_dz", i), rdz, exp[2*W]);
         chk_lat($sformatf("rnd%0d_lat", i), o, exp[2*W], lat);
         chk($sformatf("rnd%0d_stable", i), stable, 1);
         cur_hi = exp[2*W-1:W];
         cur_lo = exp[W-1:0];
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
